// File: rtl/mfp_adc_max10_fifo.sv
// Circular sample buffer for the MAX10 ADC response stream, with a first-word-fall-through pop port.
// Define ADC_FIFO_TIMESTAMP_EN to store a 12-bit free-running timestamp with each entry.
module mfp_adc_max10_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RESETn,
  input  logic                  ADC_R_Valid,
  input  logic [4:0]            ADC_R_Channel,
  input  logic [11:0]           ADC_R_Data,
  input  logic                  ADC_R_SOP,
  input  logic                  ADC_R_EOP,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DEPTH_LOG2:0]   threshold,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  FIFO_Interrupt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] ONE = PW'(1);

`ifdef ADC_FIFO_TIMESTAMP_EN
  localparam int EW = 31;
`else
  localparam int EW = 19;
`endif

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, level_q, next_level;
  logic          ovf_q, irq_q, irq_next;
  logic          empty, full, pop_ok, push_ok, drop;
  logic [EW-1:0] entry_in, head;
  logic [11:0]   ts_out;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
  assign pop_ok  = pop && !empty;
  // A full buffer still accepts a sample when the head is freed in the same cycle.
  assign push_ok = ADC_R_Valid && (!full || pop_ok);
  assign drop    = ADC_R_Valid && full && !pop_ok;

`ifdef ADC_FIFO_TIMESTAMP_EN
  logic [11:0] ts_cnt;

  always_ff @(posedge CLK) begin
    if (!RESETn) ts_cnt <= 12'd0;
    else         ts_cnt <= ts_cnt + 12'd1;
  end

  assign entry_in = {ts_cnt, ADC_R_EOP, ADC_R_SOP, ADC_R_Channel, ADC_R_Data};
  assign ts_out   = head[30:19];
`else
  assign entry_in = {ADC_R_EOP, ADC_R_SOP, ADC_R_Channel, ADC_R_Data};
  assign ts_out   = 12'd0;
`endif

  always_ff @(posedge CLK) begin
    if (RESETn && !clear && push_ok)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= entry_in;
  end

  always_comb begin
    next_level = level_q;
    if (clear)
      next_level = '0;
    else if (push_ok && !pop_ok)
      next_level = level_q + ONE;
    else if (pop_ok && !push_ok)
      next_level = level_q - ONE;
    irq_next = (threshold != '0) && (next_level >= threshold);
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      level_q <= next_level;
      irq_q   <= irq_next;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_q  <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + ONE;
        if (pop_ok)  rd_ptr <= rd_ptr + ONE;
        if (drop)    ovf_q  <= 1'b1;
      end
    end
  end

  assign head           = mem[rd_ptr[DEPTH_LOG2-1:0]];
  assign rd_valid       = !empty;
  assign rd_data        = rd_valid ? {1'b1, ts_out, head[18:0]} : 32'd0;
  assign level          = level_q;
  assign overflow       = ovf_q;
  assign FIFO_Interrupt = irq_q;

endmodule

// File: tb/tb_mfp_adc_max10_fifo.sv
// Directed self-checking bench for mfp_adc_max10_fifo (DEPTH_LOG2=4).
// Timestamp checks are built only when ADC_FIFO_TIMESTAMP_EN is defined.
module tb_mfp_adc_max10_fifo;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        valid;
  logic [4:0]  ch;
  logic [11:0] data;
  logic        sop, eop, pop, clear;
  logic [4:0]  threshold;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic        overflow, irq;

  int n_tests = 0;
  int n_fail  = 0;

  mfp_adc_max10_fifo #(.DEPTH_LOG2(4)) dut (
    .CLK            (CLK),
    .RESETn         (RESETn),
    .ADC_R_Valid    (valid),
    .ADC_R_Channel  (ch),
    .ADC_R_Data     (data),
    .ADC_R_SOP      (sop),
    .ADC_R_EOP      (eop),
    .pop            (pop),
    .clear          (clear),
    .threshold      (threshold),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .level          (level),
    .overflow       (overflow),
    .FIFO_Interrupt (irq)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [4:0] c, input logic [11:0] d, input logic s, input logic e);
    valid = 1'b1; ch = c; data = d; sop = s; eop = e;
    tick();
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    RESETn = 1'b0; valid = 0; ch = 0; data = 0; sop = 0; eop = 0;
    pop = 0; clear = 0; threshold = 0;
    tick(); tick();
    check_val("rst_level", 32'(level), 32'd0);
    check_val("rst_valid", 32'(rd_valid), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    check_val("rst_irq", 32'(irq), 32'd0);
    check_val("rst_data", rd_data, 32'd0);
    RESETn = 1'b1;
    tick();

    // single sample
    push(5'd3, 12'hABC, 1'b1, 1'b1);
    check_val("single_valid", 32'(rd_valid), 32'd1);
    check_val("single_low", 32'(rd_data[18:0]), 32'h63ABC);
    check_val("single_bit31", 32'(rd_data[31]), 32'd1);
    check_val("single_level", 32'(level), 32'd1);
`ifndef ADC_FIFO_TIMESTAMP_EN
    check_val("no_ts_field", 32'(rd_data[30:19]), 32'd0);
`endif
    do_pop();
    check_val("pop_valid", 32'(rd_valid), 32'd0);
    check_val("pop_level", 32'(level), 32'd0);
    check_val("pop_data", rd_data, 32'd0);

    // fill, overflow, drain in order
    for (int i = 0; i < 16; i++) push(5'd1, 12'(i), 1'b0, 1'b0);
    push(5'd1, 12'h0FF, 1'b0, 1'b0);
    check_val("full_level", 32'(level), 32'd16);
    check_val("full_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check_val($sformatf("drain_%0d", i), 32'(rd_data[11:0]), 32'(i));
      do_pop();
    end
    check_val("drain_level", 32'(level), 32'd0);
    check_val("drain_valid", 32'(rd_valid), 32'd0);
    check_val("drain_ovf_sticky", 32'(overflow), 32'd1);

    clear = 1'b1; tick(); clear = 1'b0;
    check_val("clear_ovf", 32'(overflow), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push(5'd2, 12'(12'h100 + i), 1'b0, 1'b0);
    valid = 1'b1; data = 12'h1AA; pop = 1'b1;
    tick();
    valid = 1'b0; pop = 1'b0;
    check_val("pp_level", 32'(level), 32'd16);
    check_val("pp_ovf", 32'(overflow), 32'd0);
    check_val("pp_head", 32'(rd_data[11:0]), 32'h101);
    for (int i = 0; i < 15; i++) do_pop();
    check_val("pp_last", 32'(rd_data[11:0]), 32'h1AA);
    check_val("pp_last_level", 32'(level), 32'd1);
    do_pop();
    check_val("pp_empty", 32'(rd_valid), 32'd0);

    // threshold interrupt
    threshold = 5'd4;
    for (int i = 1; i <= 3; i++) push(5'd0, 12'(i), 1'b0, 1'b0);
    check_val("irq_3", 32'(irq), 32'd0);
    push(5'd0, 12'd4, 1'b0, 1'b0);
    check_val("irq_4", 32'(irq), 32'd1);
    check_val("irq_4_level", 32'(level), 32'd4);
    do_pop();
    check_val("irq_pop", 32'(irq), 32'd0);
    for (int i = 0; i < 13; i++) push(5'd0, 12'(i), 1'b0, 1'b0);
    check_val("irq_full_level", 32'(level), 32'd16);
    check_val("irq_full", 32'(irq), 32'd1);
    threshold = 5'd0;
    tick();
    check_val("irq_disabled", 32'(irq), 32'd0);

    // clear beats push/pop and overflow
    push(5'd0, 12'h777, 1'b0, 1'b0);
    check_val("ovf_set", 32'(overflow), 32'd1);
    clear = 1'b1; valid = 1'b1; data = 12'h333; pop = 1'b1;
    tick();
    clear = 1'b0; valid = 1'b0; pop = 1'b0;
    check_val("clr_level", 32'(level), 32'd0);
    check_val("clr_ovf", 32'(overflow), 32'd0);
    check_val("clr_valid", 32'(rd_valid), 32'd0);
    tick();
    check_val("clr_nostore", 32'(rd_valid), 32'd0);
    do_pop();
    check_val("empty_pop_level", 32'(level), 32'd0);
    check_val("empty_pop_valid", 32'(rd_valid), 32'd0);

    // push and pop together on empty buffer
    valid = 1'b1; data = 12'h5A5; ch = 5'd7; pop = 1'b1;
    tick();
    valid = 1'b0; pop = 1'b0;
    check_val("emp_pp_level", 32'(level), 32'd1);
    check_val("emp_pp_data", 32'(rd_data[16:0]), 32'h75A5);
    do_pop();

    // reset mid-operation
    push(5'd0, 12'h011, 1'b0, 1'b0);
    push(5'd0, 12'h022, 1'b0, 1'b0);
    RESETn = 1'b0;
    tick();
    check_val("mid_rst_level", 32'(level), 32'd0);
    check_val("mid_rst_valid", 32'(rd_valid), 32'd0);
    check_val("mid_rst_data", rd_data, 32'd0);
    RESETn = 1'b1;
    tick();

`ifdef ADC_FIFO_TIMESTAMP_EN
    begin
      logic [11:0] t0, t1, tz;
      int n;
      push(5'd0, 12'hA01, 1'b0, 1'b0);
      t0 = rd_data[30:19];
      for (int i = 0; i < 4; i++) tick();
      push(5'd0, 12'hA02, 1'b0, 1'b0);
      do_pop();
      t1 = rd_data[30:19];
      check_val("ts_diff5", 32'(t1 - t0), 32'd5);
      do_pop();
      push(5'd0, 12'hA03, 1'b0, 1'b0);
      tz = rd_data[30:19];
      n = int'(12'(12'd4093 - tz));
      for (int i = 0; i < n; i++) tick();
      push(5'd0, 12'hA04, 1'b0, 1'b0);
      tick(); tick();
      push(5'd0, 12'hA05, 1'b0, 1'b0);
      do_pop();
      check_val("ts_4094", 32'(rd_data[30:19]), 32'd4094);
      do_pop();
      check_val("ts_wrap", 32'(rd_data[30:19]), 32'd1);
      do_pop();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
